// File: rtl/banco_reg_pkg.sv
// Shared defaults and helpers for the banco_reg_multi register file.
// Optional feature macro: BANCO_REG_BYPASS_EN (write-first forwarding on read ports).
package banco_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_REG   = 0;

  // True for an index that names a real, writable register.
  function automatic logic addr_ok(input int addr, input int depth);
    addr_ok = (addr != ZERO_REG) && (addr < depth);
  endfunction

endpackage

// File: rtl/banco_reg_rdport.sv
// One registered read port of banco_reg_multi (1-cycle latency, rd_en/rd_valid).
// Optional feature macro: BANCO_REG_BYPASS_EN selects write-first forwarding;
// without it a same-cycle read of the register being written returns the old contents.
module banco_reg_rdport
  import banco_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid
);

  logic [DATA_W-1:0] value_s;
  logic [DATA_W-1:0] rdata_r;
  logic              rd_valid_r;

`ifndef BANCO_REG_BYPASS_EN
  // Write-port signals only matter when forwarding is built in.
  logic unused_wr_s;
  assign unused_wr_s = ^{we, waddr, wdata};
`endif

  // Select the value this port would capture: zero for index 0 / out of range.
  always_comb begin
    value_s = {DATA_W{1'b0}};
    if (addr_ok(32'(raddr), DEPTH)) begin
`ifdef BANCO_REG_BYPASS_EN
      if (we && (waddr == raddr)) begin
        value_s = wdata;
      end else begin
        value_s = regs[raddr];
      end
`else
      value_s = regs[raddr];
`endif
    end else begin
      value_s = {DATA_W{1'b0}};
    end
  end

  // Capture read data on request; data holds and valid drops when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r    <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (rd_en) begin
      rdata_r    <= value_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rdata    = rdata_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/banco_reg_multi.sv
// Parametrised register bank: one write port, NUM_RD registered read ports.
// Register 0 reads as zero; writes to 0 or beyond DEPTH are dropped.
// Optional feature macro: BANCO_REG_BYPASS_EN (write-first forwarding on read ports).
module banco_reg_multi
  import banco_reg_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_RD = NUM_RD_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_valid
);

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic              wr_hit_s;

  // Qualify the write: enabled, not register 0, inside the array.
  always_comb begin
    wr_hit_s = 1'b0;
    if (we && addr_ok(32'(waddr), DEPTH)) begin
      wr_hit_s = 1'b1;
    end else begin
      wr_hit_s = 1'b0;
    end
  end

  // Register array; entry 0 is only ever cleared, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_hit_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    banco_reg_rdport #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .clk      (clk),
      .rst_n    (rst_n),
      .regs     (regs_r),
      .rd_en    (rd_en[gi]),
      .raddr    (raddr[gi*ADDR_W +: ADDR_W]),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[gi*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[gi])
    );
  end

endmodule

// File: tb/tb_banco_reg_multi.sv
// Self-checking bench for banco_reg_multi at defaults (32 x 32 bits, 2 read ports).
// Honours BANCO_REG_BYPASS_EN for the same-cycle hazard expectation.
module tb_banco_reg_multi;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  rd_en;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rd_valid;

  int n_cmp;
  int n_bad;

`ifdef BANCO_REG_BYPASS_EN
  localparam logic [31:0] HAZ_EXP = 32'd70;
`else
  localparam logic [31:0] HAZ_EXP = 32'd216;
`endif

  typedef struct {
    string       nm;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  en;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl[$];

  banco_reg_multi dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .raddr    (raddr),
    .rdata    (rdata),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic w, input int wa, input int wd,
                              input logic [1:0] en, input int r0, input int r1,
                              input logic [1:0] ev, input int e0, input int e1);
    vec_t v;
    v.nm = nm; v.we = w; v.waddr = 5'(wa); v.wdata = 32'(wd);
    v.en = en; v.ra0 = 5'(r0); v.ra1 = 5'(r1);
    v.ev = ev; v.e0 = 32'(e0); v.e1 = 32'(e1);
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [1:0] ev, input logic [31:0] e0,
                       input logic [31:0] e1);
    cmp({nm, ".valid"}, 32'(rd_valid), 32'(ev));
    cmp({nm, ".rdata0"}, rdata[31:0], e0);
    cmp({nm, ".rdata1"}, rdata[63:32], e1);
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1);
    we = w; waddr = wa; wdata = wd; rd_en = en; raddr = {r1, r0};
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v.we, v.waddr, v.wdata, v.en, v.ra0, v.ra1);
    @(posedge clk);
    #1;
    check(v.nm, v.ev, v.e0, v.e1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);

    // Fill the vector table.
    for (int k = 1; k < 32; k++) tbl.push_back(mk("fill", 1'b1, k, 12 * k, 2'b00, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk("rd_26_27", 1'b0, 0, 0, 2'b11, 26, 27, 2'b11, 312, 324));
    tbl.push_back(mk("rd_31_1", 1'b0, 0, 0, 2'b11, 31, 1, 2'b11, 372, 12));
    tbl.push_back(mk("rd_same", 1'b0, 0, 0, 2'b11, 7, 7, 2'b11, 84, 84));
    tbl.push_back(mk("wr0_rd0", 1'b1, 0, 32'hDEAD, 2'b11, 0, 0, 2'b11, 0, 0));
    tbl.push_back(mk("rd0_after", 1'b0, 0, 0, 2'b11, 0, 0, 2'b11, 0, 0));
    tbl.push_back(mk("hazard", 1'b1, 18, 70, 2'b11, 18, 17, 2'b11, int'(HAZ_EXP), 204));
    tbl.push_back(mk("post_haz", 1'b0, 18, 15, 2'b11, 18, 18, 2'b11, 70, 70));
    tbl.push_back(mk("we0_keep", 1'b0, 18, 15, 2'b11, 18, 3, 2'b11, 70, 36));
    tbl.push_back(mk("pulse", 1'b0, 18, 15, 2'b10, 20, 9, 2'b10, 70, 108));
    tbl.push_back(mk("hold1", 1'b0, 0, 0, 2'b00, 1, 2, 2'b00, 70, 108));
    tbl.push_back(mk("hold2", 1'b0, 0, 0, 2'b00, 3, 4, 2'b00, 70, 108));

    // Reset sequence: release, store a value, then assert reset between edges.
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("wr5", 1'b1, 5, 32'h55, 2'b00, 0, 0, 2'b00, 0, 0));
    step(mk("rd5_pre", 1'b0, 0, 0, 2'b11, 5, 5, 2'b11, 32'h55, 32'h55));
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h66, 2'b11, 5'd5, 5'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 2'b00, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold", 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    step(mk("rd5_post", 1'b0, 0, 0, 2'b11, 5, 5, 2'b11, 0, 0));
    step(mk("rd6_post", 1'b0, 0, 0, 2'b01, 6, 0, 2'b01, 0, 0));

    // Table-driven main body.
    foreach (tbl[i]) step(tbl[i]);

    // Reset lands while a read request is pending.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd15, 5'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrd_async", 2'b00, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("midrd_edge", 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrd_after", 2'b00, 32'd0, 32'd0);
    step(mk("rd15_30", 1'b0, 0, 0, 2'b11, 15, 30, 2'b11, 0, 0));
    step(mk("rd18_rst", 1'b0, 0, 0, 2'b11, 18, 26, 2'b11, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
